lcd_read_cycle: RTL and testbench
=================================

// Module: lcd_read_cycle
// PURPOSE
//  Read-side counterpart of the LCD write-cycle engine: runs one HD44780 read bus cycle
//  (RW=1) on request and returns the sampled DB byte.
//  Optionally polls the busy flag, repeating reads with RS=0 until BF (DB[7]) clears or a
//  poll limit is hit.
//  Sits beside write_cycle under lcd_controller; the controller ORs E_out/RW_out/RS_out
//  with the writer's and tri-states DB with DB_oe.
// PARAMETERS
//  SETUP_TICKS   1   clk_1ms cycles with RS/RW stable and E low before E rises (>=1)
//  E_HIGH_TICKS  1   cycles E_out held high; DB sampled on the last of them (>=1)
//  HOLD_TICKS    1   cycles E low with RW still 1 after E falls (>=1)
//  MAX_POLLS     16  maximum number of read cycles in one busy-poll transaction (>=1)
// PORTS
//  clk_1ms       in   1  system clock (1 ms tick); all logic on rising edge
//  reset         in   1  synchronous, active-high reset
//  rd_enable     in   1  request pulse; accepted only in IDLE
//  reg_sel       in   1  RS for a plain read (0 = status/AC, 1 = data RAM); latched on accept
//  poll_busy     in   1  1 = busy-poll transaction (RS forced 0); latched on accept
//  DB_in         in   8  LCD data bus as seen by the FPGA
//  E_out         out  1  LCD enable strobe, registered
//  RW_out        out  1  1 during a read transaction, registered
//  RS_out        out  1  register select, registered
//  DB_oe         out  1  1 = FPGA may drive DB; 0 for the whole transaction
//  rd_data       out  8  last sampled DB byte; held until the next accept
//  rd_finish     out  1  one-cycle completion pulse
//  busy_timeout  out  1  valid with rd_finish: 1 = poll ended with BF still 1
// BEHAVIOUR
//  Reset: E_out=0, RW_out=0, RS_out=0, DB_oe=1, rd_data=8'h00, rd_finish=0, busy_timeout=0,
//   state=IDLE, counters=0.
//  FSM (all outputs registered from state):
//   IDLE   : RW=0, DB_oe=1, E=0. On rd_enable, latch reg_sel and poll_busy, clear poll_cnt,
//            go to SETUP.
//   SETUP  : RW=1, DB_oe=0, E=0, RS = poll ? 0 : reg_sel_q. Lasts SETUP_TICKS, then E_HIGH.
//   E_HIGH : E=1 for E_HIGH_TICKS. rd_data <= DB_in at the clock edge that ends the last
//            E_HIGH cycle. Then HOLD.
//   HOLD   : E=0, RW=1, DB_oe=0 for HOLD_TICKS, then CHECK (0-cycle decision, combinational).
//   CHECK  : if !poll -> DONE.
//            if poll & rd_data[7]=0 -> DONE with busy_timeout=0.
//            if poll & BF=1 & poll_cnt < MAX_POLLS-1 -> poll_cnt++, SETUP.
//            else -> DONE with busy_timeout=1.
//   DONE   : rd_finish=1 for exactly 1 cycle, RW=0, DB_oe=1, then IDLE.
//  Latency (defaults, plain read): rd_enable high in cycle 0.
//   SETUP c1, E_HIGH c2, HOLD c3, rd_finish c4; next request accepted in c5.
//   Each extra poll adds SETUP+E_HIGH+HOLD ticks.
//  rd_enable outside IDLE is ignored (no queueing). rd_enable held high re-triggers in IDLE
//   after DONE.
//  rd_data is not modified except at the E_HIGH sample edge. busy_timeout is cleared on accept.
//  Bus rule: DB_oe=0 whenever RW_out=1; E_out=1 only while RW_out=1.
//  Reset mid-transaction: next edge forces reset values (E drops, bus released to FPGA),
//   no rd_finish.
//  Phase counter width: clog2 of max(SETUP,E_HIGH,HOLD)+1. poll_cnt width: clog2(MAX_POLLS)+1.
// STRUCTURE
//  Shared package lcd_pkg: FSM state localparams (IDLE,SETUP,E_HIGH,HOLD,DONE),
//   LCD_BF_BIT=7, RS_CMD=0 / RS_DATA=1.
//  One sub-module: lcd_phase_timer. It loads a tick count and asserts phase_done on the last
//   tick; reused for all three phases.
// TESTING
//  1 Defaults, reg_sel=1, DB_in=8'hA5, rd_enable pulse c0 -> E_out=1 only c2.
//    RW_out=1 and DB_oe=0 c1-c3, RS_out=1, rd_finish c4, rd_data=8'hA5.
//  2 poll_busy=1, DB_in[7]=1 for first 3 reads then 8'h12 -> 4 E pulses, RS_out=0 throughout.
//    rd_finish once, rd_data=8'h12, busy_timeout=0.
//  3 poll_busy=1, MAX_POLLS=4, DB_in=8'h80 constant -> exactly 4 E pulses, then rd_finish
//    with busy_timeout=1.
//  4 rd_enable re-pulsed during E_HIGH with DB_in changing -> ignored, single rd_finish,
//    rd_data from the first sample.
//  5 reset asserted in E_HIGH -> next edge E_out=0, RW_out=0, DB_oe=1, no rd_finish.
//    A new request afterwards completes normally.
//  6 SETUP_TICKS=2, E_HIGH_TICKS=3, HOLD_TICKS=2 -> E high exactly c3-c5, sample at end of c5,
//    rd_finish c8. Bus-rule assertion checked in every test.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 read-cycle engine: FSM states, bus constants
// and a small elaboration-time helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        DONE
    } lcd_state_t;

    localparam int   LCD_BF_BIT = 7;
    localparam logic RS_CMD     = 1'b0;
    localparam logic RS_DATA    = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_read_cycle_if.sv
// Request/response and LCD bus signals of the read-cycle engine.
// The master side is the controller, the slave side is the engine itself.
interface lcd_read_cycle_if;

    logic       rd_enable;
    logic       reg_sel;
    logic       poll_busy;
    logic [7:0] DB_in;
    logic       E_out;
    logic       RW_out;
    logic       RS_out;
    logic       DB_oe;
    logic [7:0] rd_data;
    logic       rd_finish;
    logic       busy_timeout;

    modport master (
        output rd_enable, reg_sel, poll_busy, DB_in,
        input  E_out, RW_out, RS_out, DB_oe, rd_data, rd_finish, busy_timeout
    );

    modport slave (
        input  rd_enable, reg_sel, poll_busy, DB_in,
        output E_out, RW_out, RS_out, DB_oe, rd_data, rd_finish, busy_timeout
    );

endinterface

// File: rtl/lcd_phase_timer.sv
// Down-counter shared by the SETUP, E_HIGH and HOLD phases: load a tick count on
// phase entry, phase_done is high during the last tick of the phase.
module lcd_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             phase_done
);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - WIDTH'(1);
        end
    end

    assign phase_done = (cnt_reg == WIDTH'(1));

endmodule

// File: rtl/lcd_read_cycle.sv
// HD44780 read bus cycle engine: one RW=1 read per request, or repeated status reads
// until the busy flag clears or the poll limit is reached.
module lcd_read_cycle
    import lcd_pkg::*;
#(
    parameter int SETUP_TICKS  = 1,
    parameter int E_HIGH_TICKS = 1,
    parameter int HOLD_TICKS   = 1,
    parameter int MAX_POLLS    = 16
) (
    input  logic             clk_1ms,
    input  logic             reset,
    lcd_read_cycle_if.slave  bus
);

    localparam int PHASE_MAX = max3(SETUP_TICKS, E_HIGH_TICKS, HOLD_TICKS);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int POLL_W    = $clog2(MAX_POLLS) + 1;

    localparam logic [PHASE_W-1:0] SETUP_LEN = PHASE_W'(SETUP_TICKS);
    localparam logic [PHASE_W-1:0] E_LEN     = PHASE_W'(E_HIGH_TICKS);
    localparam logic [PHASE_W-1:0] HOLD_LEN  = PHASE_W'(HOLD_TICKS);
    localparam logic [POLL_W-1:0]  POLL_LAST = POLL_W'(MAX_POLLS - 1);

    lcd_state_t          state_reg;
    logic                poll_reg;
    logic [POLL_W-1:0]   poll_cnt_reg;
    logic                e_reg;
    logic                rw_reg;
    logic                rs_reg;
    logic                oe_reg;
    logic [7:0]          rd_data_reg;
    logic                finish_reg;
    logic                timeout_reg;

    logic                timer_load;
    logic [PHASE_W-1:0]  timer_val;
    logic                phase_done;
    logic                bf_set;
    logic                repoll;

    // The busy flag is judged on the byte just sampled, which is already in rd_data_reg during HOLD.
    assign bf_set = poll_reg && rd_data_reg[LCD_BF_BIT];
    assign repoll = bf_set && (poll_cnt_reg < POLL_LAST);

    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            IDLE:   if (bus.rd_enable)          begin timer_load = 1'b1; timer_val = SETUP_LEN; end
            SETUP:  if (phase_done)             begin timer_load = 1'b1; timer_val = E_LEN;     end
            E_HIGH: if (phase_done)             begin timer_load = 1'b1; timer_val = HOLD_LEN;  end
            HOLD:   if (phase_done && repoll)   begin timer_load = 1'b1; timer_val = SETUP_LEN; end
            default: ;
        endcase
    end

    lcd_phase_timer #(
        .WIDTH(PHASE_W)
    ) u_phase_timer (
        .clk        (clk_1ms),
        .reset      (reset),
        .load       (timer_load),
        .load_val   (timer_val),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state_reg    <= IDLE;
            poll_reg     <= 1'b0;
            poll_cnt_reg <= '0;
            e_reg        <= 1'b0;
            rw_reg       <= 1'b0;
            rs_reg       <= RS_CMD;
            oe_reg       <= 1'b1;
            rd_data_reg  <= 8'h00;
            finish_reg   <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            finish_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.rd_enable) begin
                        poll_reg     <= bus.poll_busy;
                        poll_cnt_reg <= '0;
                        timeout_reg  <= 1'b0;
                        rw_reg       <= 1'b1;
                        oe_reg       <= 1'b0;
                        rs_reg       <= (bus.poll_busy || !bus.reg_sel) ? RS_CMD : RS_DATA;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        e_reg     <= 1'b1;
                        state_reg <= E_HIGH;
                    end
                end
                E_HIGH: begin
                    if (phase_done) begin
                        e_reg       <= 1'b0;
                        rd_data_reg <= bus.DB_in;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        if (repoll) begin
                            poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
                            state_reg    <= SETUP;
                        end else begin
                            finish_reg  <= 1'b1;
                            timeout_reg <= bf_set;
                            rw_reg      <= 1'b0;
                            oe_reg      <= 1'b1;
                            rs_reg      <= RS_CMD;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.E_out        = e_reg;
    assign bus.RW_out       = rw_reg;
    assign bus.RS_out       = rs_reg;
    assign bus.DB_oe        = oe_reg;
    assign bus.rd_data      = rd_data_reg;
    assign bus.rd_finish    = finish_reg;
    assign bus.busy_timeout = timeout_reg;

endmodule

// File: tb/tb_lcd_read_cycle.sv
// Bench for lcd_read_cycle: two instances (default timing / stretched timing with a
// short poll limit) checked every cycle against a timeline model, plus directed cases.
module tb_lcd_read_cycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       chk_en = 1'b0;
    logic       rd_en [2];
    logic       reg_sel [2];
    logic       poll [2];
    logic [7:0] db [2];
    logic       e_o [2];
    logic       rw_o [2];
    logic       rs_o [2];
    logic       oe_o [2];
    logic       fin_o [2];
    logic       to_o [2];
    logic [7:0] data_o [2];

    lcd_read_cycle_if bus0 ();
    lcd_read_cycle_if bus1 ();

    assign bus0.rd_enable = rd_en[0];
    assign bus0.reg_sel   = reg_sel[0];
    assign bus0.poll_busy = poll[0];
    assign bus0.DB_in     = db[0];
    assign bus1.rd_enable = rd_en[1];
    assign bus1.reg_sel   = reg_sel[1];
    assign bus1.poll_busy = poll[1];
    assign bus1.DB_in     = db[1];

    assign e_o[0] = bus0.E_out;   assign e_o[1] = bus1.E_out;
    assign rw_o[0] = bus0.RW_out; assign rw_o[1] = bus1.RW_out;
    assign rs_o[0] = bus0.RS_out; assign rs_o[1] = bus1.RS_out;
    assign oe_o[0] = bus0.DB_oe;  assign oe_o[1] = bus1.DB_oe;
    assign fin_o[0] = bus0.rd_finish;     assign fin_o[1] = bus1.rd_finish;
    assign to_o[0] = bus0.busy_timeout;   assign to_o[1] = bus1.busy_timeout;
    assign data_o[0] = bus0.rd_data;      assign data_o[1] = bus1.rd_data;

    lcd_read_cycle #(
        .SETUP_TICKS(1), .E_HIGH_TICKS(1), .HOLD_TICKS(1), .MAX_POLLS(16)
    ) dut0 (
        .clk_1ms (clk),
        .reset   (reset),
        .bus     (bus0.slave)
    );

    lcd_read_cycle #(
        .SETUP_TICKS(2), .E_HIGH_TICKS(3), .HOLD_TICKS(2), .MAX_POLLS(4)
    ) dut1 (
        .clk_1ms (clk),
        .reset   (reset),
        .bus     (bus1.slave)
    );

    function automatic int ps(input int i);   return (i == 0) ? 1 : 2;  endfunction
    function automatic int pe(input int i);   return (i == 0) ? 1 : 3;  endfunction
    function automatic int ph(input int i);   return (i == 0) ? 1 : 2;  endfunction
    function automatic int pmax(input int i); return (i == 0) ? 16 : 4; endfunction

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Timeline model: a transaction is a sequence of reads of S+E+H cycles each,
    // followed by one completion cycle; m_off is the cycle offset inside the current read.
    logic       m_act [2];
    logic       m_done [2];
    logic       m_poll [2];
    logic       m_rs [2];
    logic       m_to [2];
    int         m_off [2];
    int         m_reads [2];
    logic [7:0] m_data [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_data[i] <= 8'h00;
                m_to[i] <= 1'b0; m_off[i] <= 0; m_reads[i] <= 0;
                m_poll[i] <= 1'b0; m_rs[i] <= 1'b0;
            end else if (m_done[i]) begin
                m_done[i] <= 1'b0;
            end else if (!m_act[i]) begin
                if (rd_en[i]) begin
                    m_act[i] <= 1'b1; m_off[i] <= 0; m_reads[i] <= 0;
                    m_poll[i] <= poll[i]; m_rs[i] <= poll[i] ? 1'b0 : reg_sel[i];
                    m_to[i] <= 1'b0;
                end
            end else begin
                if (m_off[i] == ps(i) + pe(i) - 1)
                    m_data[i] <= db[i];
                if (m_off[i] == ps(i) + pe(i) + ph(i) - 1) begin
                    if (m_poll[i] && m_data[i][7] && (m_reads[i] + 1 < pmax(i))) begin
                        m_reads[i] <= m_reads[i] + 1;
                        m_off[i] <= 0;
                    end else begin
                        m_act[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_to[i] <= m_poll[i] && m_data[i][7];
                    end
                end else begin
                    m_off[i] <= m_off[i] + 1;
                end
            end
        end
    end

    logic exp_e;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_e = m_act[i] && (m_off[i] >= ps(i)) && (m_off[i] < ps(i) + pe(i));
                chk($sformatf("dut%0d E_out", i), e_o[i], exp_e);
                chk($sformatf("dut%0d RW_out", i), rw_o[i], m_act[i]);
                chk($sformatf("dut%0d DB_oe", i), oe_o[i], !m_act[i]);
                if (m_act[i])
                    chk($sformatf("dut%0d RS_out", i), rs_o[i], m_rs[i]);
                chk($sformatf("dut%0d rd_finish", i), fin_o[i], m_done[i]);
                chk($sformatf("dut%0d rd_data", i), data_o[i], m_data[i]);
                chk($sformatf("dut%0d busy_timeout", i), to_o[i], m_to[i]);
                chk($sformatf("dut%0d bus_rule_oe", i), oe_o[i], !rw_o[i]);
                chk($sformatf("dut%0d bus_rule_e", i), e_o[i] && !rw_o[i], 1'b0);
                if (fin_o[i] === 1'b1)
                    $display("txn dut%0d: rd_data=%h busy_timeout=%b t=%0t", i, data_o[i], to_o[i], $time);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int idx, input int n, input bit bf_seq,
                             output int pulses, output int fins, output int rs_hi);
        bit e_prev;
        e_prev = 1'b0;
        pulses = 0; fins = 0; rs_hi = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) rd_en[idx] = 1'b0;
            if (bf_seq) db[idx] = (m_reads[idx] < 3) ? 8'hC3 : 8'h12;
            @(negedge clk);
            if (e_o[idx] && !e_prev) pulses++;
            e_prev = e_o[idx];
            if (fin_o[idx]) fins++;
            if (rw_o[idx] && rs_o[idx]) rs_hi++;
        end
    endtask

    int pulses, fins, rs_hi;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd_en[i] = 1'b0; reg_sel[i] = 1'b0; poll[i] = 1'b0; db[i] = 8'h00;
        end
        reset = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset E_out%0d", i), e_o[i], 1'b0);
            chk($sformatf("reset RW_out%0d", i), rw_o[i], 1'b0);
            chk($sformatf("reset DB_oe%0d", i), oe_o[i], 1'b1);
            chk($sformatf("reset rd_data%0d", i), data_o[i], 8'h00);
        end
        next_cycle();
        reset = 1'b0;

        // Plain data read with default timing.
        next_cycle();
        rd_en[0] = 1'b1; reg_sel[0] = 1'b1; poll[0] = 1'b0; db[0] = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) rd_en[0] = 1'b0;
            @(negedge clk);
            chk($sformatf("t1 E c%0d", k), e_o[0], (k == 2));
            chk($sformatf("t1 RW c%0d", k), rw_o[0], (k >= 1 && k <= 3));
            chk($sformatf("t1 DB_oe c%0d", k), oe_o[0], !(k >= 1 && k <= 3));
            chk($sformatf("t1 rd_finish c%0d", k), fin_o[0], (k == 4));
            if (k >= 1 && k <= 3) chk($sformatf("t1 RS c%0d", k), rs_o[0], 1'b1);
        end
        chk("t1 rd_data", data_o[0], 8'hA5);

        // Busy poll: BF set on the first three reads, clear on the fourth.
        next_cycle();
        rd_en[0] = 1'b1; reg_sel[0] = 1'b1; poll[0] = 1'b1;
        run_count(0, 20, 1'b1, pulses, fins, rs_hi);
        chk("t2 E pulses", 8'(pulses), 8'd4);
        chk("t2 rd_finish count", 8'(fins), 8'd1);
        chk("t2 RS high cycles", 8'(rs_hi), 8'd0);
        chk("t2 rd_data", data_o[0], 8'h12);
        chk("t2 busy_timeout", to_o[0], 1'b0);

        // Busy poll that never clears, limit of four reads.
        next_cycle();
        rd_en[1] = 1'b1; reg_sel[1] = 1'b0; poll[1] = 1'b1; db[1] = 8'h80;
        run_count(1, 40, 1'b0, pulses, fins, rs_hi);
        chk("t3 E pulses", 8'(pulses), 8'd4);
        chk("t3 rd_finish count", 8'(fins), 8'd1);
        chk("t3 busy_timeout", to_o[1], 1'b1);
        chk("t3 rd_data", data_o[1], 8'h80);

        // Request re-pulsed during E_HIGH while DB changes afterwards.
        next_cycle();
        rd_en[0] = 1'b1; reg_sel[0] = 1'b0; poll[0] = 1'b0; db[0] = 8'h3C;
        fins = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) rd_en[0] = 1'b0;
            if (k == 2) rd_en[0] = 1'b1;
            if (k == 3) begin rd_en[0] = 1'b0; db[0] = 8'hC3; end
            @(negedge clk);
            if (k == 2) chk("t4 E c2", e_o[0], 1'b1);
            if (fin_o[0]) fins++;
        end
        chk("t4 rd_finish count", 8'(fins), 8'd1);
        chk("t4 rd_data", data_o[0], 8'h3C);

        // Reset while E is high, then a fresh request.
        next_cycle();
        rd_en[0] = 1'b1; reg_sel[0] = 1'b1; db[0] = 8'h77;
        next_cycle();
        rd_en[0] = 1'b0;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("t5 E before reset", e_o[0], 1'b1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("t5 E after reset", e_o[0], 1'b0);
        chk("t5 RW after reset", rw_o[0], 1'b0);
        chk("t5 DB_oe after reset", oe_o[0], 1'b1);
        fins = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            if (fin_o[0]) fins++;
        end
        chk("t5 no rd_finish", 8'(fins), 8'd0);
        next_cycle();
        rd_en[0] = 1'b1; reg_sel[0] = 1'b1; poll[0] = 1'b0; db[0] = 8'h5E;
        run_count(0, 7, 1'b0, pulses, fins, rs_hi);
        chk("t5 new rd_finish", 8'(fins), 8'd1);
        chk("t5 new rd_data", data_o[0], 8'h5E);

        // Stretched phases on dut1.
        next_cycle();
        rd_en[1] = 1'b1; reg_sel[1] = 1'b1; poll[1] = 1'b0; db[1] = 8'h9B;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) rd_en[1] = 1'b0;
            if (k == 6) db[1] = 8'h00;
            @(negedge clk);
            chk($sformatf("t6 E c%0d", k), e_o[1], (k >= 3 && k <= 5));
            chk($sformatf("t6 rd_finish c%0d", k), fin_o[1], (k == 8));
        end
        chk("t6 rd_data", data_o[1], 8'h9B);

        // Randomized traffic on both instances, occasional reset.
        for (int n = 0; n < 600; n++) begin
            next_cycle();
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < 2; i++) begin
                rd_en[i]   = ($urandom_range(0, 3) == 0);
                reg_sel[i] = 1'($urandom_range(0, 1));
                poll[i]    = 1'($urandom_range(0, 1));
                db[i]      = 8'($urandom_range(0, 255));
                db[i][7]   = ($urandom_range(0, 2) != 0);
            end
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) rd_en[i] = 1'b0;
        repeat (40) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
